// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit multi-cycle CPU.
//   - opcode_e  : 4-bit opcode field of the instruction register (IR[7:4])
//   - state_e   : FSM states (fetch, execute, data read, halted)
//   - reg_idx_t : index into the four-entry register file
//   - helpers classifying opcodes by operand form and flag behaviour
package cpu_pkg;

  localparam int NUM_REGS = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LD  = 4'h2,
    OP_MOV = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_NOT = 4'h9,
    OP_SHL = 4'hA,
    OP_JMP = 4'hB,
    OP_JZ  = 4'hC,
    OP_JC  = 4'hD,
    OP_JR  = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_DATA  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef logic [1:0] reg_idx_t;

  // One-register forms take their register index from IR[1:0] instead of
  // the usual rd field IR[3:2].
  function automatic logic is_one_reg(input opcode_e op);
    return (op == OP_LDI) || (op == OP_LD) || (op == OP_NOT) ||
           (op == OP_SHL) || (op == OP_JR);
  endfunction

  // ALU operations: write the ALU result to rd and update both Z and C.
  function automatic logic writes_flags(input opcode_e op);
    return (op >= OP_ADD) && (op <= OP_SHL);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: purely combinational 8-bit ALU for opcodes ADD..SHL.
// Ports:
//   a      in  8  first operand (rd value)
//   b      in  8  second operand (rs value; ignored by NOT/SHL)
//   op     in  4  opcode from IR[7:4]
//   result out 8  operation result, wraps modulo 256
//   z      out 1  result == 0
//   c      out 1  carry (ADD), borrow (SUB), old bit 7 (SHL), else 0
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  output logic [7:0] result,
  output logic       z,
  output logic       c
);

  opcode_e    w_op;
  logic [8:0] w_sum;

  assign w_op  = opcode_e'(op);
  assign w_sum = {1'b0, a} + {1'b0, b};

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    result = a;
    c      = 1'b0;
    case (w_op)
      OP_ADD: begin
        result = w_sum[7:0];
        c      = w_sum[8];
      end
      OP_SUB: begin
        result = a - b;
        c      = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[6:0], 1'b0};
        c      = a[7];
      end
      default: begin
        result = a;
        c      = 1'b0;
      end
    endcase
  end

  assign z = (result == 8'h00);

endmodule

// File: rtl/cpu.sv
// cpu: minimal 8-bit multi-cycle von Neumann CPU with one read-only memory
// port shared between instruction fetch, operand fetch and data loads.
// Ports:
//   clk      in  1  clock, all state changes on the rising edge
//   rst      in  1  asynchronous active-low reset
//   memVal   in  8  byte at memAddr, valid combinationally in the same cycle
//   memAddr  out 8  memory address: PC, or the operand latch during DATA
// Instruction format: IR[7:4] opcode, IR[3:2] rd, IR[1:0] rs (or rd for
// one-register forms). Two-byte instructions read their operand at PC in
// the EXEC cycle.
module cpu
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] memVal,
  output logic [7:0] memAddr
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [7:0] r_pc;
  logic [7:0] w_pc_nxt;
  logic [7:0] r_ir;
  logic [7:0] w_ir_nxt;
  logic [7:0] r_opr;
  logic [7:0] w_opr_nxt;
  logic [7:0] r_regs [NUM_REGS];
  logic       r_z;
  logic       r_c;

  opcode_e    w_op;
  reg_idx_t   w_rd;
  reg_idx_t   w_rs;
  logic [7:0] w_rd_val;
  logic [7:0] w_rs_val;
  logic [7:0] w_pc_inc;

  logic [7:0] w_alu_res;
  logic       w_alu_z;
  logic       w_alu_c;

  logic       w_reg_we;
  logic [7:0] w_reg_wdata;
  logic       w_flag_we;

  assign w_op     = opcode_e'(r_ir[7:4]);
  assign w_rs     = r_ir[1:0];
  assign w_rd     = is_one_reg(w_op) ? r_ir[1:0] : r_ir[3:2];
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];
  // Natural 8-bit wrap takes PC from 0xFF to 0x00, also mid-instruction.
  assign w_pc_inc = r_pc + 8'd1;

  cpu_alu u_alu (
    .a      (w_rd_val),
    .b      (w_rs_val),
    .op     (r_ir[7:4]),
    .result (w_alu_res),
    .z      (w_alu_z),
    .c      (w_alu_c)
  );

  // Next-state, datapath control and the memAddr mux.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_opr_nxt   = r_opr;
    w_reg_we    = 1'b0;
    w_reg_wdata = 8'h00;
    w_flag_we   = 1'b0;
    memAddr     = r_pc;

    case (r_state)
      S_FETCH: begin
        w_ir_nxt    = memVal;
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = S_EXEC;
      end

      S_EXEC: begin
        // memAddr stays on PC: two-byte ops consume memVal as their operand,
        // single-byte ops ignore it.
        w_state_nxt = S_FETCH;
        if (writes_flags(w_op)) begin
          w_reg_we    = 1'b1;
          w_reg_wdata = w_alu_res;
          w_flag_we   = 1'b1;
        end
        case (w_op)
          OP_LDI: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = memVal;
            w_pc_nxt    = w_pc_inc;
          end
          OP_LD: begin
            w_opr_nxt   = memVal;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_DATA;
          end
          OP_MOV: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_rs_val;
          end
          OP_JMP: w_pc_nxt = memVal;
          OP_JZ:  w_pc_nxt = r_z ? memVal : w_pc_inc;
          OP_JC:  w_pc_nxt = r_c ? memVal : w_pc_inc;
          OP_JR:  w_pc_nxt = w_rs_val;
          OP_HLT: w_state_nxt = S_HALT;
          default: begin
            // NOP, and ALU ops already handled above.
          end
        endcase
      end

      S_DATA: begin
        memAddr     = r_opr;
        w_reg_we    = 1'b1;
        w_reg_wdata = memVal;
        w_state_nxt = S_FETCH;
      end

      S_HALT: begin
        w_state_nxt = S_HALT;
      end

      default: w_state_nxt = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= 8'h00;
      r_ir  <= 8'h00;
      r_opr <= 8'h00;
      r_z   <= 1'b0;
      r_c   <= 1'b0;
      // NOTE: this register file is architectural state that must read zero
      // after reset, so it is reset like ordinary flops rather than left to
      // power-up contents as a RAM would be.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      r_pc  <= w_pc_nxt;
      r_ir  <= w_ir_nxt;
      r_opr <= w_opr_nxt;
      if (w_reg_we) begin
        r_regs[w_rd] <= w_reg_wdata;
      end
      if (w_flag_we) begin
        r_z <= w_alu_z;
        r_c <= w_alu_c;
      end
    end
  end

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: self-checking bench for cpu. A behavioural 256x8 ROM with a
// combinational read feeds memVal. Each program's expected memAddr trace is
// pushed onto a scoreboard queue and popped one entry per clock cycle.
module tb_cpu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] memVal;
  logic [7:0] memAddr;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  assign memVal = mem[memAddr];

  cpu dut (
    .clk     (clk),
    .rst     (rst),
    .memVal  (memVal),
    .memAddr (memAddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] a);
    exp_q.push_back(a);
  endtask

  // Pops one expected address per cycle, sampling mid-low-phase.
  task automatic run_trace(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s[%0d]: scoreboard empty, got 0x%02h", tag, i, memAddr);
      end else begin
        check($sformatf("%s[%0d]", tag, i), memAddr, exp_q.pop_front());
      end
      @(negedge clk);
    end
  endtask

  // Asserts reset asynchronously and checks memAddr drops without a clock.
  task automatic begin_reset(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_async"}, memAddr, 8'h00);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    exp_q.delete();
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_hold"}, memAddr, 8'h00);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    // ---- Reset, NOP fill and HLT at 0x06 ----
    begin_reset("rst0");
    @(negedge clk);
    release_reset("rst0");
    mem[8'h06] = 8'hF0;
    push(8'h00); push(8'h01); push(8'h01); push(8'h02); push(8'h02);
    push(8'h03); push(8'h03); push(8'h04); push(8'h04); push(8'h05);
    push(8'h05); push(8'h06); push(8'h06);
    for (int i = 0; i < 8; i++) push(8'h07);
    run_trace("hlt", 21);

    // ---- LDI/ADD/JR: r0 = 5 + 3, jump to 0x08 ----
    begin_reset("rst1");
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h05; mem[8'h02] = 8'h11;
    mem[8'h03] = 8'h03; mem[8'h04] = 8'h41; mem[8'h05] = 8'hE0;
    release_reset("rst1");
    push(8'h00); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    push(8'h05); push(8'h05); push(8'h06); push(8'h08); push(8'h09);
    push(8'h09);
    run_trace("addjr", 11);

    // ---- LD r2,[0x80]; JR r2 -> 0x30 ----
    begin_reset("rst2");
    mem[8'h00] = 8'h22; mem[8'h01] = 8'h80; mem[8'h02] = 8'hE2;
    mem[8'h80] = 8'h30;
    release_reset("rst2");
    push(8'h00); push(8'h01); push(8'h80); push(8'h02); push(8'h03);
    push(8'h30); push(8'h31);
    run_trace("ld", 7);

    // ---- Flags: ADD carry/zero, JC, JZ taken and not taken, SUB borrow ----
    begin_reset("rst3");
    mem[8'h00] = 8'h10; mem[8'h01] = 8'hFF; mem[8'h02] = 8'h11;
    mem[8'h03] = 8'h01; mem[8'h04] = 8'h41; mem[8'h05] = 8'hD0;
    mem[8'h06] = 8'h40;
    mem[8'h40] = 8'hC0; mem[8'h41] = 8'h50;
    mem[8'h50] = 8'h10; mem[8'h51] = 8'h07; mem[8'h52] = 8'h11;
    mem[8'h53] = 8'h07; mem[8'h54] = 8'h51; mem[8'h55] = 8'hC0;
    mem[8'h56] = 8'h60;
    mem[8'h60] = 8'h10; mem[8'h61] = 8'h05; mem[8'h62] = 8'h11;
    mem[8'h63] = 8'h03; mem[8'h64] = 8'h51; mem[8'h65] = 8'hC0;
    mem[8'h66] = 8'h70; mem[8'h67] = 8'hD0; mem[8'h68] = 8'h70;
    mem[8'h69] = 8'h51; mem[8'h6A] = 8'hD0; mem[8'h6B] = 8'h80;
    release_reset("rst3");
    push(8'h00); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    push(8'h05); push(8'h05); push(8'h06); push(8'h40); push(8'h41);
    push(8'h50); push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    push(8'h55); push(8'h55); push(8'h56); push(8'h60); push(8'h61);
    push(8'h62); push(8'h63); push(8'h64); push(8'h65); push(8'h65);
    push(8'h66); push(8'h67); push(8'h68); push(8'h69); push(8'h6A);
    push(8'h6A); push(8'h6B); push(8'h80); push(8'h81);
    run_trace("flags", 34);

    // ---- Logic ops, SHL carry, MOV keeps flags, HLT ----
    // AND 3C&0F=0C; OR A5|5A=FF; NOT->00 (Z); XOR C3^5A=99; SHL->32 (C);
    // MOV r3,r2 then JC still taken.
    begin_reset("rst4");
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h3C; mem[8'h02] = 8'h11;
    mem[8'h03] = 8'h0F; mem[8'h04] = 8'h61; mem[8'h05] = 8'hE0;
    mem[8'h0C] = 8'h12; mem[8'h0D] = 8'hA5; mem[8'h0E] = 8'h13;
    mem[8'h0F] = 8'h5A; mem[8'h10] = 8'h7B; mem[8'h11] = 8'h92;
    mem[8'h12] = 8'hC0; mem[8'h13] = 8'h20;
    mem[8'h20] = 8'h12; mem[8'h21] = 8'hC3; mem[8'h22] = 8'h8B;
    mem[8'h23] = 8'hA2; mem[8'h24] = 8'hD0; mem[8'h25] = 8'h30;
    mem[8'h30] = 8'hE2;
    mem[8'h32] = 8'h3E; mem[8'h33] = 8'hD0; mem[8'h34] = 8'h44;
    mem[8'h44] = 8'hF0;
    release_reset("rst4");
    push(8'h00); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    push(8'h05); push(8'h05); push(8'h06); push(8'h0C); push(8'h0D);
    push(8'h0E); push(8'h0F); push(8'h10); push(8'h11); push(8'h11);
    push(8'h12); push(8'h12); push(8'h13); push(8'h20); push(8'h21);
    push(8'h22); push(8'h23); push(8'h23); push(8'h24); push(8'h24);
    push(8'h25); push(8'h30); push(8'h31); push(8'h32); push(8'h33);
    push(8'h33); push(8'h34); push(8'h44); push(8'h45); push(8'h45);
    push(8'h45);
    run_trace("alu", 36);

    // ---- PC wrap during fetch and operand fetch ----
    // JMP 0xFF; LDI at 0xFF takes its operand from 0x00; 0x01 holds 0xFF (HLT).
    begin_reset("rst5");
    mem[8'h00] = 8'hB0; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h10;
    release_reset("rst5");
    push(8'h00); push(8'h01); push(8'hFF); push(8'h00); push(8'h01);
    push(8'h02); push(8'h02); push(8'h02);
    run_trace("wrap", 8);

    // ---- Async reset during LD's DATA cycle: no write to r2 ----
    begin_reset("rst6");
    mem[8'h00] = 8'h22; mem[8'h01] = 8'h80; mem[8'h80] = 8'h30;
    release_reset("rst6");
    push(8'h00); push(8'h01);
    run_trace("ldabort", 2);
    #1;
    check("ldabort_data", memAddr, 8'h80);
    rst = 1'b0;
    #1;
    check("ldabort_async", memAddr, 8'h00);
    // Replace the program with JR r2: r2 must still be zero.
    mem[8'h00] = 8'hE2; mem[8'h01] = 8'h00;
    exp_q.delete();
    release_reset("rst7");
    push(8'h00); push(8'h01); push(8'h00); push(8'h01);
    run_trace("r2zero", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu.md
# cpu

Minimal 8-bit multi-cycle von Neumann CPU that fetches instructions and data through a single read-only memory port. It sits above the existing `Memory` block, a 256x8 ROM initialised from a hex file with a combinational read. The CPU drives `memAddr` and reads `memVal` back in the same cycle. All architectural effects are observable on `memAddr`.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `memVal` input 8: byte read from `Memory` at `memAddr`, valid combinationally in the same cycle.
- `memAddr` output 8: memory address, a combinational mux of PC and the operand latch.

## Operation
- State: PC[7:0], IR[7:0], OPR[7:0], r0–r3 (each 8 bits), flags Z and C, FSM state.
- IR format: [7:4] opcode, [3:2] rd, [1:0] rs. One-register forms use [1:0] as rd.
- FSM states: FETCH, EXEC, DATA, HALT.
- FETCH: `memAddr`=PC; IR←`memVal`; PC←PC+1; next state EXEC.
- EXEC, single-byte ops: perform the op; `memAddr`=PC with the value ignored; next state FETCH.
- EXEC, two-byte ops: `memAddr`=PC; operand←`memVal`; PC←PC+1 unless a jump is taken.
- DATA: `memAddr`=OPR; rd←`memVal`; next state FETCH.
- HALT: `memAddr`=PC, held forever; only reset exits.
- Opcodes:
  - 0 NOP.
  - 1 LDI rd,#imm: rd←imm.
  - 2 LD rd,[a]: OPR←a, then DATA state.
  - 3 MOV rd,rs.
  - 4 ADD rd,rs: C = carry out.
  - 5 SUB rd,rs: C = borrow (rd<rs).
  - 6 AND, 7 OR, 8 XOR: C←0.
  - 9 NOT rd: C←0.
  - A SHL rd: C←old bit7, bit0←0.
  - B JMP a.
  - C JZ a: taken if Z=1.
  - D JC a: taken if C=1.
  - E JR rs: PC←rs.
  - F HLT.
- Flags: Z←(result==0) for opcodes 4–A only. LDI, LD, MOV and jumps leave flags unchanged.
- Arithmetic is 8-bit and wraps modulo 256. PC wraps 0xFF→0x00, including during operand fetch.
- Jump not taken: PC skips the operand byte (PC+1 past it).

## Timing
- Reset (`rst`=0, asynchronous): PC=0, IR=0, OPR=0, all registers 0, Z=C=0, state FETCH, so `memAddr`=0x00 immediately.
- First fetch occurs at the first rising edge after `rst` deasserts.
- Cycles per instruction: 2 for single-byte ops, LDI and jumps; 3 for LD; 2 for HLT, then frozen.
- Jump target appears on `memAddr` in the FETCH cycle immediately after EXEC.
- A reset mid-instruction (including in DATA) aborts the instruction with no partial register write; the next cycle after release fetches address 0x00.
- No stalls or wait states; memory is assumed zero-latency.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants: OP_NOP … OP_HLT;
  - FSM state enum: S_FETCH, S_EXEC, S_DATA, S_HALT;
  - register-index type.
- Sub-module `cpu_alu`: combinational; inputs a, b and op; outputs result[7:0], z and c.
- `cpu` holds the FSM, PC, IR, OPR, register file, flags and the `memAddr` mux.
- `Memory` is an existing, separate block and is not part of this block.

## Test plan
- Reset: hold `rst`=0 → `memAddr`=0x00 and all registers 0. Release → `memAddr` sequence 0x00, 0x01, … with NOP fill.
- ADD/JR: program 0x10 0x05 0x11 0x03 0x41 0xE0 → after JR, the FETCH cycle drives `memAddr`=0x08 with r0=0x08.
- LD: program 0x22 0x80 0xE2 with mem[0x80]=0x30 → DATA cycle drives `memAddr`=0x80; the fetch after JR drives `memAddr`=0x30.
- Flags:
  - LDI r0,#0xFF; LDI r1,#0x01; ADD r0,r1 → Z=1, C=1.
  - JC 0x40 → `memAddr`=0x40.
  - SUB equal registers then JZ → taken.
  - JZ with Z=0 → falls through to PC+2.
- HLT (0xF0 at address 0x06) → `memAddr` holds 0x07 for all subsequent cycles.
- Async reset asserted during LD's DATA cycle → `memAddr`=0x00 without waiting for a clock edge; destination register stays 0.
